ultra_echo_emulator: RTL and testbench
======================================

# ultra_echo_emulator

- Synthesizable model of an HC-SR04-style ultrasonic sensor: the responder end of the trigg/echo link driven by `peripheral_ultra`.
- Watches `trigg` and qualifies the trigger pulse, waits a burst delay, then drives `echo` high for a time set by a programmed distance.
- Distance is programmed over the same cs/rd/wr/addr bus used by the other peripherals.
- Used for closed-loop simulation and on-board self-test without a physical sensor.

## Interface
- TICKS_PER_US, 50, clk cycles per microsecond (50 MHz).
- TRIG_MIN_US, 10, minimum accepted trigger high time.
- BURST_DELAY_US, 250, trigger-fall to echo-rise delay.
- US_PER_CM, 58, echo microseconds per cm.
- MAX_CM, 400, largest valid distance.
- TIMEOUT_US, 38000, echo width for no object.
- HOLDOFF_US, 1000, dead time after echo falls.
- DEFAULT_CM, 100, distance register reset value.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- d_in  in  16  bus write data.
- cs  in  1  chip select.
- addr  in  4  register address.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_out  out  16  registered read data.
- trigg  in  1  trigger from the initiator; asynchronous, 2-flop synchronized.
- echo  out  1  echo pulse to the initiator.

## Operation
- Register map:
  - 0x0: distance, R/W, 16 bits.
  - 0x2: status, R: bit0 busy (state≠IDLE), bit1 echo, bits[4:2] state code.
  - 0x4: accepted-trigger count, R, wraps at 16 bits.
  - 0x6: rejected-trigger count, R, wraps; a write clears it.
- Write occurs when `cs & wr`. Read occurs when `cs & rd`; other addresses read 0.
- `wr` has priority if both strobes are asserted.
- Microsecond prescaler counts 0..TICKS_PER_US-1 and emits `us_tick`. It restarts on every state change, so all durations are exact multiples of TICKS_PER_US.
- FSM states:
  - IDLE: wait for synchronized `trigg`=1, then go to TRIG.
  - TRIG: count µs while `trigg` is high. On fall:
    - count ≥ TRIG_MIN_US: accepted count +1, latch echo_us, go to BURST.
    - otherwise: rejected count +1, go to IDLE.
  - BURST: wait BURST_DELAY_US, then go to ECHO.
  - ECHO: `echo`=1 for echo_us, then go to HOLDOFF.
  - HOLDOFF: wait HOLDOFF_US, then go to IDLE.
- Echo width rule: echo_us = distance×US_PER_CM when 1 ≤ distance ≤ MAX_CM; otherwise echo_us = TIMEOUT_US.
  - Multiply is 16×7 bits, truncated to 17 bits (no overflow in the valid range).
  - Out-of-range distances, including 0, use the timeout value.
- `trigg` edges in BURST, ECHO or HOLDOFF are ignored and not counted.
- A distance write during a measurement affects the next trigger only (echo_us is latched at TRIG→BURST).
- Simultaneous accept and a write to 0x6: the rejected count clears and the accepted count increments.

## Timing
- Reset values: `echo`=0, `d_out`=0, state IDLE, distance=DEFAULT_CM, both counters 0, prescaler 0.
- A reset asserted mid-pulse drops `echo` at the next clk edge.
- `trigg` has 2 cycles of synchronizer latency.
- `echo` rises exactly 3 + TICKS_PER_US×BURST_DELAY_US cycles after the first clk edge sampling `trigg` low.
- `echo` high width is exactly TICKS_PER_US×echo_us cycles.
- `d_out` is valid 1 cycle after `cs & rd` and holds until the next read.

## Configuration
- ULTRA_EMU_NOISE_EN defined: a 16-bit LFSR (seed 16'hACE1 on reset, advanced once per accepted trigger) adds 0..15 µs (LFSR[3:0]) to echo_us.
- ULTRA_EMU_NOISE_EN undefined: echo width is exact and deterministic.

## Structure
- Shared package `ultra_pkg`: FSM state encodings, register address constants (distance/status/accepted/rejected), and the TIMEOUT_US and US_PER_CM defaults shared with `peripheral_ultra`.
- One sub-module, `ultra_us_tick`: parameterized prescaler with a synchronous restart input and a 1-cycle `us_tick` output.

## Test plan
- Reset with no bus activity, then read 0x0 → `d_out`=100, `echo`=0, status=0.
- Write 0x0=1, then apply `trigg` high for 500 cycles → `echo` rises 3+12500 cycles after the fall and stays high 2900 cycles; read 0x4 → 1.
- Apply `trigg` high for 499 cycles → no `echo`; read 0x6 → 1. Write 0x6, then read → 0.
- Write distance 0, trigger; repeat with distance 401 → `echo` high 1,900,000 cycles in both cases.
- Write distance 2 while in ECHO with distance 5 → current echo is 14500 cycles, next is 5800 cycles. A trigger during HOLDOFF leaves 0x4 and 0x6 unchanged.
- Assert `rst` mid-echo → `echo`=0 on the next edge and state is IDLE. A valid trigger afterwards produces a full DEFAULT_CM echo of 290000 cycles.

Source files
------------

// File: rtl/ultra_pkg.sv
// Shared definitions for the ultrasonic sensor emulator and its initiator peripheral.
package ultra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG    = 3'd1,
        ST_BURST   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } ultra_state_e;

    localparam logic [3:0] ADDR_DISTANCE = 4'h0;
    localparam logic [3:0] ADDR_STATUS   = 4'h2;
    localparam logic [3:0] ADDR_ACCEPTED = 4'h4;
    localparam logic [3:0] ADDR_REJECTED = 4'h6;

    localparam int unsigned TIMEOUT_US_DEF = 38000;
    localparam int unsigned US_PER_CM_DEF  = 58;
    localparam int unsigned ECHO_W         = 17;

    // Fibonacci LFSR, taps 16/14/13/11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/ultra_us_tick.sv
// Microsecond prescaler: one-cycle tick every TICKS clocks, restartable from zero.
module ultra_us_tick #(
    parameter int unsigned TICKS = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic us_tick_o
);

    localparam int unsigned PW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q;

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (restart_i || presc_q == PW'(TICKS - 1)) begin
            presc_d = '0;
        end
    end

    // tick_q is high exactly while presc_q sits at its terminal value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= (presc_d == PW'(TICKS - 1));
        end
    end

    assign us_tick_o = tick_q;

endmodule

// File: rtl/ultra_echo_emulator.sv
// HC-SR04-style responder: qualifies trigg, waits a burst delay, returns an echo sized by distance.
// Define ULTRA_EMU_NOISE_EN to add 0..15 us of LFSR jitter to every echo.
module ultra_echo_emulator
    import ultra_pkg::*;
#(
    parameter int unsigned TICKS_PER_US   = 50,
    parameter int unsigned TRIG_MIN_US    = 10,
    parameter int unsigned BURST_DELAY_US = 250,
    parameter int unsigned US_PER_CM      = US_PER_CM_DEF,
    parameter int unsigned MAX_CM         = 400,
    parameter int unsigned TIMEOUT_US     = TIMEOUT_US_DEF,
    parameter int unsigned HOLDOFF_US     = 1000,
    parameter int unsigned DEFAULT_CM     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        trigg,
    output logic        echo
);

    ultra_state_e      state_q, state_d;
    logic [ECHO_W-1:0] cnt_q, cnt_d;
    logic [ECHO_W-1:0] echo_us_q, echo_calc_c;
    logic [15:0]       distance_q, acc_q, rej_q, d_out_q, rd_data_c;
    logic              trig_meta_q, trig_sync_q, echo_q;
    logic              us_tick, restart_c, accept_c, reject_c, wr_c, rd_c;
    logic              in_range_c;
    logic [ECHO_W-1:0] prod_c;

    assign wr_c = cs & wr;
    assign rd_c = cs & rd & ~wr;

    ultra_us_tick #(.TICKS(TICKS_PER_US)) u_tick (
        .clk_i     (clk),
        .rst_i     (rst),
        .restart_i (restart_c),
        .us_tick_o (us_tick)
    );

    // Echo width for the currently programmed distance
    assign in_range_c = (distance_q != 16'd0) && (distance_q <= 16'(MAX_CM));
    assign prod_c     = ECHO_W'(distance_q) * ECHO_W'(US_PER_CM);

`ifdef ULTRA_EMU_NOISE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (accept_c) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign echo_calc_c = (in_range_c ? prod_c : ECHO_W'(TIMEOUT_US)) + ECHO_W'(lfsr_q[3:0]);
`else
    assign echo_calc_c = in_range_c ? prod_c : ECHO_W'(TIMEOUT_US);
`endif

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        reject_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_sync_q) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                // a tick landing on the fall cycle still counts toward the pulse
                if (!trig_sync_q) begin
                    if ((cnt_q + ECHO_W'(us_tick)) >= ECHO_W'(TRIG_MIN_US)) begin
                        accept_c = 1'b1;
                        state_d  = ST_BURST;
                    end else begin
                        reject_c = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_BURST: begin
                if (us_tick && cnt_q == ECHO_W'(BURST_DELAY_US - 1)) state_d = ST_ECHO;
            end
            ST_ECHO: begin
                if (us_tick && cnt_q == echo_us_q - ECHO_W'(1)) state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (us_tick && cnt_q == ECHO_W'(HOLDOFF_US - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign restart_c = (state_d != state_q);

    // Trigger count stops at the threshold so it cannot wrap on a stuck-high trigg
    always_comb begin
        cnt_d = cnt_q;
        if (restart_c) begin
            cnt_d = '0;
        end else if (us_tick && state_q != ST_IDLE &&
                     !(state_q == ST_TRIG && cnt_q >= ECHO_W'(TRIG_MIN_US))) begin
            cnt_d = cnt_q + ECHO_W'(1);
        end
    end

    always_comb begin
        rd_data_c = '0;
        case (addr)
            ADDR_DISTANCE: rd_data_c = distance_q;
            ADDR_STATUS:   rd_data_c = {11'd0, 3'(state_q), echo_q, state_q != ST_IDLE};
            ADDR_ACCEPTED: rd_data_c = acc_q;
            ADDR_REJECTED: rd_data_c = rej_q;
            default:       rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            echo_us_q   <= '0;
            distance_q  <= 16'(DEFAULT_CM);
            acc_q       <= '0;
            rej_q       <= '0;
            echo_q      <= 1'b0;
            d_out_q     <= '0;
        end else begin
            trig_meta_q <= trigg;
            trig_sync_q <= trig_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            echo_q      <= (state_q == ST_ECHO);
            if (accept_c) begin
                echo_us_q <= echo_calc_c;
                acc_q     <= acc_q + 16'd1;
            end
            if (wr_c && addr == ADDR_DISTANCE) distance_q <= d_in;
            if (wr_c && addr == ADDR_REJECTED) begin
                rej_q <= '0;
            end else if (reject_c) begin
                rej_q <= rej_q + 16'd1;
            end
            if (rd_c) d_out_q <= rd_data_c;
        end
    end

    assign echo  = echo_q;
    assign d_out = d_out_q;

endmodule

// File: tb/tb_ultra_echo_emulator.sv
// Directed bench for ultra_echo_emulator with shortened timing parameters.
module tb_ultra_echo_emulator;

    localparam int unsigned T    = 2;
    localparam int unsigned TMIN = 10;
    localparam int unsigned B    = 5;
    localparam int unsigned UPC  = 3;
    localparam int unsigned MAXC = 400;
    localparam int unsigned TO   = 200;
    localparam int unsigned HO   = 20;
    localparam int unsigned DEF  = 100;
    localparam int          RISE = 4 + T * B;
    localparam int          SETTLE = HO * T + 10;

    logic        clk = 1'b0;
    logic        rst, cs, rd, wr, trigg, echo;
    logic [15:0] d_in, d_out;
    logic [3:0]  addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ultra_echo_emulator #(
        .TICKS_PER_US   (T),
        .TRIG_MIN_US    (TMIN),
        .BURST_DELAY_US (B),
        .US_PER_CM      (UPC),
        .MAX_CM         (MAXC),
        .TIMEOUT_US     (TO),
        .HOLDOFF_US     (HO),
        .DEFAULT_CM     (DEF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .trigg (trigg),
        .echo  (echo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] q);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        q  = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Trigger pulse of len cycles; measures fall-to-rise latency and echo width.
    // op 1 writes a/d during the echo, op 2 reads a during the echo into mid.
    task automatic pulse(input int len, input int op, input logic [3:0] a, input logic [15:0] d,
                         output int rise, output int width, output logic [15:0] mid);
        mid = '0;
        @(negedge clk);
        trigg = 1'b1;
        repeat (len) @(negedge clk);
        trigg = 1'b0;
        rise = 0;
        do begin
            @(negedge clk);
            rise++;
        end while (echo !== 1'b1 && rise < 200);
        width = 0;
        while (echo === 1'b1 && width < 5000) begin
            width++;
            if (width == 2 && op != 0) begin
                cs = 1'b1; addr = a; d_in = d; wr = (op == 1); rd = (op == 2);
            end
            if (width == 3 && op != 0) begin
                mid = d_out;
                cs = 1'b0; wr = 1'b0; rd = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          r, w, k, highs;
        logic [15:0] q, m;

        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; trigg = 1'b0;
        addr = '0; d_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset_echo", 32'(echo), 0);
        chk("reset_dout", 32'(d_out), 0);
        bus_read(4'h0, q); chk("reset_distance", 32'(q), DEF);
        bus_read(4'h2, q); chk("reset_status", 32'(q), 0);
        bus_read(4'h4, q); chk("reset_acc", 32'(q), 0);
        bus_read(4'h6, q); chk("reset_rej", 32'(q), 0);
        bus_read(4'h8, q); chk("unmapped_read", 32'(q), 0);

        // shortest valid trigger, distance 1
        bus_write(4'h0, 16'd1);
        pulse(TMIN * T, 0, 4'h0, 16'd0, r, w, m);
        chk("d1_rise", 32'(r), 32'(RISE));
        chk("d1_width", 32'(w), 1 * UPC * T);
        repeat (SETTLE) @(negedge clk);
        bus_read(4'h4, q); chk("acc_after_d1", 32'(q), 1);

        // one cycle short of the minimum trigger: rejected, no echo
        @(negedge clk);
        trigg = 1'b1;
        repeat (TMIN * T - 1) @(negedge clk);
        trigg = 1'b0;
        highs = 0;
        repeat (RISE + 20) begin
            @(negedge clk);
            if (echo === 1'b1) highs++;
        end
        chk("short_no_echo", 32'(highs), 0);
        bus_read(4'h6, q); chk("rej_after_short", 32'(q), 1);
        bus_read(4'h4, q); chk("acc_after_short", 32'(q), 1);
        bus_write(4'h6, 16'hFFFF);
        bus_read(4'h6, q); chk("rej_cleared", 32'(q), 0);

        // out-of-range distances fall back to the timeout width
        bus_write(4'h0, 16'd0);
        pulse(TMIN * T, 0, 4'h0, 16'd0, r, w, m);
        chk("d0_width", 32'(w), TO * T);
        repeat (SETTLE) @(negedge clk);
        bus_write(4'h0, 16'd401);
        pulse(TMIN * T, 0, 4'h0, 16'd0, r, w, m);
        chk("d401_width", 32'(w), TO * T);
        repeat (SETTLE) @(negedge clk);

        // largest valid distance, with a status read mid-echo
        bus_write(4'h0, 16'd400);
        pulse(TMIN * T + 6, 2, 4'h2, 16'd0, r, w, m);
        chk("d400_rise", 32'(r), 32'(RISE));
        chk("d400_width", 32'(w), 400 * UPC * T);
        chk("status_in_echo", 32'(m), 32'h0F);
        repeat (SETTLE) @(negedge clk);

        // distance rewritten mid-echo only affects the next trigger
        bus_write(4'h0, 16'd5);
        pulse(TMIN * T, 1, 4'h0, 16'd2, r, w, m);
        chk("d5_width", 32'(w), 5 * UPC * T);
        // trigger inside HOLDOFF must be ignored
        trigg = 1'b1;
        repeat (TMIN * T) @(negedge clk);
        trigg = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("holdoff_no_echo", 32'(echo), 0);
        bus_read(4'h4, q); chk("acc_after_holdoff", 32'(q), 5);
        bus_read(4'h6, q); chk("rej_after_holdoff", 32'(q), 0);
        bus_read(4'h0, q); chk("distance_rewritten", 32'(q), 2);
        pulse(TMIN * T, 0, 4'h0, 16'd0, r, w, m);
        chk("d2_rise", 32'(r), 32'(RISE));
        chk("d2_width", 32'(w), 2 * UPC * T);
        repeat (SETTLE) @(negedge clk);
        bus_read(4'h4, q); chk("acc_after_d2", 32'(q), 6);

        // reset in the middle of an echo
        @(negedge clk);
        trigg = 1'b1;
        repeat (TMIN * T) @(negedge clk);
        trigg = 1'b0;
        k = 0;
        while (echo !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("echo_before_rst", 32'(echo), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_echo_drop", 32'(echo), 0);
        chk("rst_dout", 32'(d_out), 0);
        rst = 1'b0;
        bus_read(4'h2, q); chk("rst_status_idle", 32'(q), 0);
        bus_read(4'h0, q); chk("rst_distance", 32'(q), DEF);
        bus_read(4'h4, q); chk("rst_acc", 32'(q), 0);
        pulse(TMIN * T, 0, 4'h0, 16'd0, r, w, m);
        chk("post_rst_rise", 32'(r), 32'(RISE));
        chk("post_rst_width", 32'(w), DEF * UPC * T);
        repeat (SETTLE) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
